// File: rtl/draw_pkg.sv
// ============================================================================
// Module   : draw_pkg
// Brief    : Shared pixel-field widths for the board-drawing engines and the
//            state type of the draw sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package draw_pkg;

    // Pixel bus field widths shared by every drawing engine and the adapter
    localparam int X_W = 9;
    localparam int Y_W = 8;
    localparam int C_W = 3;

    // Sequencer control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } seq_state_t;

endpackage : draw_pkg

`default_nettype wire

// File: rtl/cmd_fifo.sv
// ============================================================================
// Module   : cmd_fifo
// Brief    : Synchronous command FIFO holding engine indices. Push while full
//            and pop while empty are ignored. Head is a combinational read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_fifo
    import draw_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Flags come straight from the occupancy register, so they are glitch-free
    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule : cmd_fifo

`default_nettype wire

// File: rtl/draw_sequencer.sv
// ============================================================================
// Module   : draw_sequencer
// Brief    : Queues draw commands and runs one engine at a time through its
//            level start/done handshake, muxing the active engine's pixel
//            stream onto the single VGA adapter write port.
//            Optional watchdog: define DRAW_SEQ_WATCHDOG_EN to abort a job
//            that stays in RUN for TIMEOUT_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_sequencer
    import draw_pkg::*;
#(
    parameter int N_ENG       = 4,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 131072
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [$clog2(N_ENG)-1:0] cmd_eng,
    output logic [N_ENG-1:0]         eng_start,
    input  logic [N_ENG-1:0]         eng_done,
    input  logic [N_ENG*X_W-1:0]     eng_x,
    input  logic [N_ENG*Y_W-1:0]     eng_y,
    input  logic [N_ENG*C_W-1:0]     eng_colour,
    input  logic [N_ENG-1:0]         eng_plot,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [C_W-1:0]           vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic                     err_timeout
);

    localparam int c_sel_w = $clog2(N_ENG);

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [c_sel_w-1:0] r_sel;
    logic [c_sel_w-1:0] w_fifo_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_sel_done;
    logic               w_timeout;
    logic [N_ENG-1:0]   r_eng_start;

    assign w_push = cmd_valid && !w_fifo_full;

    cmd_fifo #(
        .WIDTH (c_sel_w),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (cmd_eng),
        .pop   (w_pop),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // Only the selected engine's done is ever looked at
    assign w_sel_done = eng_done[r_sel];

    // Next-state logic; the pop happens on the IDLE->RUN transition
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_sel_done || w_timeout) begin
                    w_state_next = RELEASE;
                end
            end
            RELEASE: begin
                // Wait for done to drop so a stale level cannot end the next job
                if (!w_sel_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, selected slot and registered one-hot start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_eng_start <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                r_sel       <= w_fifo_head;
                r_eng_start <= N_ENG'(1) << w_fifo_head;
            end else if (w_state_next != RUN) begin
                r_eng_start <= '0;
            end
        end
    end

`ifdef DRAW_SEQ_WATCHDOG_EN
    localparam logic [16:0] c_wd_last = 17'(TIMEOUT_CYC - 1);

    logic [16:0] r_wd_cnt;

    // Counts RUN cycles of the current job; zero in the first RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (w_pop) begin
            r_wd_cnt <= '0;
        end else if (r_state == RUN) begin
            r_wd_cnt <= r_wd_cnt + 17'd1;
        end
    end

    assign w_timeout = (r_state == RUN) && !w_sel_done && (r_wd_cnt == c_wd_last);
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign w_timeout            = 1'b0;
`endif

    assign err_timeout = w_timeout;

    // Zero-latency pixel mux; the adapter sees nothing outside RUN
    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (r_state == RUN) begin
            vga_x      = eng_x[X_W*int'(r_sel) +: X_W];
            vga_y      = eng_y[Y_W*int'(r_sel) +: Y_W];
            vga_colour = eng_colour[C_W*int'(r_sel) +: C_W];
            vga_plot   = eng_plot[r_sel];
        end
    end

    assign eng_start = r_eng_start;
    assign cmd_ready = !w_fifo_full;
    assign busy      = (r_state != IDLE) || !w_fifo_empty;

endmodule : draw_sequencer

`default_nettype wire

// File: tb/tb_draw_sequencer.sv
// ============================================================================
// Module   : tb_draw_sequencer
// Brief    : Self-checking bench for draw_sequencer. Engines are modelled as
//            random pixel sources; the expected job order is a plain queue.
//            Build with DRAW_SEQ_WATCHDOG_EN to exercise the watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_sequencer;

    localparam int N_ENG       = 4;
    localparam int CMD_DEPTH   = 4;
    localparam int TIMEOUT_CYC = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_eng;
    logic [N_ENG-1:0]   eng_start;
    logic [N_ENG-1:0]   eng_done;
    logic [N_ENG*9-1:0] eng_x;
    logic [N_ENG*8-1:0] eng_y;
    logic [N_ENG*3-1:0] eng_colour;
    logic [N_ENG-1:0]   eng_plot;
    logic [8:0]         vga_x;
    logic [7:0]         vga_y;
    logic [2:0]         vga_colour;
    logic               vga_plot;
    logic               busy;
    logic               err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int q[$];

    always #5 clk = ~clk;

    draw_sequencer #(
        .N_ENG       (N_ENG),
        .CMD_DEPTH   (CMD_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_eng     (cmd_eng),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .eng_x       (eng_x),
        .eng_y       (eng_y),
        .eng_colour  (eng_colour),
        .eng_plot    (eng_plot),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    function automatic logic [N_ENG-1:0] oh(input int e);
        logic [N_ENG-1:0] v;
        v    = '0;
        v[e] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one command when the FIFO is known to have room
    task automatic push_one(input int e);
        cmd_valid = 1'b1;
        cmd_eng   = 2'(e);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL push_ready: cmd_ready=%0b required 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a start; nothing may reach the adapter meanwhile
    task automatic wait_start(input int e);
        bit got;
        got      = 1'b0;
        eng_plot = '1;
        eng_done = '0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (eng_start != '0) begin
                got = 1'b1;
            end else begin
                n_checks++;
                if (vga_plot !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_plot: vga_plot=%0b required 0", vga_plot);
                end
                tick();
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL start_timeout: no start for engine %0d within 20 cycles", e);
        end else if (eng_start !== oh(e)) begin
            n_fail++;
            $display("FAIL start_sel: eng_start=%b required %b", eng_start, oh(e));
        end
    endtask

    // Active engine streams random pixels while the others emit junk
    task automatic drive_pixels(input int e, input int n, input bit corners);
        logic [8:0] px;
        logic [7:0] py;
        logic [2:0] pc;
        logic       pp;
        for (int k = 0; k < n; k++) begin
            px = 9'(10 + $urandom_range(307));
            py = 8'(90 + $urandom_range(149));
            pc = 3'($urandom);
            pp = ($urandom_range(3) != 0);
            if (corners && k == 0)   begin px = 9'd10;  py = 8'd90;  pp = 1'b1; end
            if (corners && k == n-1) begin px = 9'd317; py = 8'd239; pp = 1'b1; end
            for (int i = 0; i < N_ENG; i++) begin
                eng_x[9*i +: 9]      = 9'($urandom);
                eng_y[8*i +: 8]      = 8'($urandom);
                eng_colour[3*i +: 3] = 3'($urandom);
                eng_plot[i]          = 1'($urandom);
                eng_done[i]          = (i != e) ? 1'($urandom) : 1'b0;
            end
            eng_x[9*e +: 9]      = px;
            eng_y[8*e +: 8]      = py;
            eng_colour[3*e +: 3] = pc;
            eng_plot[e]          = pp;
            #1;
            n_checks++;
            if ({vga_plot, vga_x, vga_y, vga_colour} !== {pp, px, py, pc}) begin
                n_fail++;
                $display("FAIL pixel: plot/x/y/c=%0b/%0d/%0d/%0d required %0b/%0d/%0d/%0d",
                         vga_plot, vga_x, vga_y, vga_colour, pp, px, py, pc);
            end
            n_checks++;
            if ({eng_start, err_timeout} !== {oh(e), 1'b0}) begin
                n_fail++;
                $display("FAIL run_start: eng_start=%b err_timeout=%0b required %b/0",
                         eng_start, err_timeout, oh(e));
            end
            tick();
        end
    endtask

    // Raise done, hold it a while in RELEASE, then clear it
    task automatic finish_job(input int e, input int hold);
        eng_done = oh(e);
        eng_plot = '1;
        tick();
        n_checks++;
        if ({eng_start, vga_plot, vga_x, vga_y, vga_colour} !== '0) begin
            n_fail++;
            $display("FAIL done_drop: start=%b plot=%0b x=%0d required all zero",
                     eng_start, vga_plot, vga_x);
        end
        for (int k = 0; k < hold; k++) begin
            tick();
            n_checks++;
            if ({eng_start, vga_plot, busy} !== {{N_ENG{1'b0}}, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL release: start=%b plot=%0b busy=%0b required 0/0/1",
                         eng_start, vga_plot, busy);
            end
        end
        eng_done = '0;
        tick();
        n_checks++;
        if ({eng_start, vga_plot} !== '0) begin
            n_fail++;
            $display("FAIL back_idle: start=%b plot=%0b required 0/0", eng_start, vga_plot);
        end
    endtask

    task automatic run_job(input int e);
        wait_start(e);
        drive_pixels(e, 1 + $urandom_range(11), 1'b0);
        finish_job(e, $urandom_range(2));
    endtask

    task automatic check_quiet(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            n_checks++;
            if ({eng_start, busy, vga_plot, err_timeout} !== '0) begin
                n_fail++;
                $display("FAIL %s: start=%b busy=%0b plot=%0b err=%0b required all zero",
                         tag, eng_start, busy, vga_plot, err_timeout);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({eng_start, busy, err_timeout, vga_plot, vga_x, vga_y, vga_colour} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: start=%b busy=%0b err=%0b plot=%0b required all zero",
                     eng_start, busy, err_timeout, vga_plot);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: cmd_ready=%0b required 1", cmd_ready);
        end
        check_quiet(3, "reset_quiet");
    endtask

    // Exact latencies of a single job on engine 0
    task automatic test_single();
        push_one(0);
        n_checks++;
        if ({eng_start, busy} !== {{N_ENG{1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL single_t1: start=%b busy=%0b required 0/1", eng_start, busy);
        end
        tick();
        n_checks++;
        if (eng_start !== oh(0)) begin
            n_fail++;
            $display("FAIL single_t2: start=%b required %b", eng_start, oh(0));
        end
        drive_pixels(0, 12, 1'b1);
        eng_done = oh(0);
        eng_plot = '1;
        tick();
        n_checks++;
        if ({eng_start, vga_plot} !== '0) begin
            n_fail++;
            $display("FAIL single_d1: start=%b plot=%0b required 0/0", eng_start, vga_plot);
        end
        tick();
        n_checks++;
        if ({eng_start, busy} !== {{N_ENG{1'b0}}, 1'b1}) begin
            n_fail++;
            $display("FAIL single_d2: start=%b busy=%0b required 0/1", eng_start, busy);
        end
        eng_done = '0;
        tick();
        n_checks++;
        if ({eng_start, busy} !== '0) begin
            n_fail++;
            $display("FAIL single_d3: start=%b busy=%0b required 0/0", eng_start, busy);
        end
    endtask

    task automatic test_back_to_back();
        push_one(0);
        push_one(2);
        push_one(1);
        run_job(0);
        run_job(2);
        run_job(1);
        check_quiet(4, "b2b_quiet");
    endtask

    task automatic test_random_queue();
        for (int r = 0; r < 3; r++) begin
            int n;
            n = 1 + $urandom_range(3);
            q.delete();
            for (int i = 0; i < n; i++) begin
                int e;
                e = $urandom_range(N_ENG - 1);
                push_one(e);
                q.push_back(e);
            end
            foreach (q[i]) run_job(q[i]);
            check_quiet(3, "rand_quiet");
        end
    endtask

    // Engine 1 plots and finishes while engine 0 owns the port
    task automatic test_isolation();
        logic [8:0] px;
        push_one(0);
        wait_start(0);
        for (int k = 0; k < 6; k++) begin
            px              = 9'($urandom);
            eng_x[8:0]      = px;
            eng_plot        = 4'b0010;
            eng_done        = 4'b0010;
            eng_x[17:9]     = 9'($urandom);
            #1;
            n_checks++;
            if ({vga_plot, vga_x, eng_start} !== {1'b0, px, oh(0)}) begin
                n_fail++;
                $display("FAIL isolation: plot=%0b x=%0d start=%b required 0/%0d/%b",
                         vga_plot, vga_x, eng_start, px, oh(0));
            end
            tick();
        end
        finish_job(0, 0);
    endtask

    task automatic test_full();
        bit exp_rdy;
        push_one(3);
        wait_start(3);
        eng_plot = '0;
        eng_done = '0;
        q.delete();
        for (int i = 0; i < 5; i++) begin
            int e;
            e         = $urandom_range(N_ENG - 1);
            exp_rdy   = (q.size() < CMD_DEPTH);
            cmd_valid = 1'b1;
            cmd_eng   = 2'(e);
            n_checks++;
            if (cmd_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL full_ready: push %0d cmd_ready=%0b required %0b", i, cmd_ready, exp_rdy);
            end
            if (exp_rdy) q.push_back(e);
            tick();
        end
        cmd_valid = 1'b0;
        exp_rdy   = (q.size() < CMD_DEPTH);
        n_checks++;
        if ({cmd_ready, eng_start} !== {exp_rdy, oh(3)}) begin
            n_fail++;
            $display("FAIL full_hold: ready=%0b start=%b required %0b/%b",
                     cmd_ready, eng_start, exp_rdy, oh(3));
        end
        finish_job(3, 0);
        foreach (q[i]) run_job(q[i]);
        check_quiet(20, "full_extra_job");
    endtask

    task automatic test_watchdog();
        push_one(3);
        push_one(2);
        wait_start(3);
        eng_done = '0;
        eng_plot = '0;
`ifdef DRAW_SEQ_WATCHDOG_EN
        for (int k = 1; k <= TIMEOUT_CYC; k++) begin
            n_checks++;
            if ({err_timeout, eng_start} !== {1'(k == TIMEOUT_CYC), oh(3)}) begin
                n_fail++;
                $display("FAIL wd_run: cycle %0d err=%0b start=%b required %0b/%b",
                         k, err_timeout, eng_start, k == TIMEOUT_CYC, oh(3));
            end
            tick();
        end
        n_checks++;
        if ({err_timeout, eng_start} !== '0) begin
            n_fail++;
            $display("FAIL wd_abort: err=%0b start=%b required 0/0", err_timeout, eng_start);
        end
`else
        for (int k = 1; k <= 40; k++) begin
            n_checks++;
            if ({err_timeout, eng_start} !== {1'b0, oh(3)}) begin
                n_fail++;
                $display("FAIL nowd_run: cycle %0d err=%0b start=%b required 0/%b",
                         k, err_timeout, eng_start, oh(3));
            end
            tick();
        end
        finish_job(3, 0);
`endif
        run_job(2);
        check_quiet(3, "wd_quiet");
    endtask

    task automatic test_reset_mid_run();
        push_one(1);
        push_one(2);
        push_one(3);
        wait_start(1);
        eng_plot = '1;
        rst      = 1'b1;
        tick();
        n_checks++;
        if ({eng_start, busy, vga_plot} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: start=%b busy=%0b plot=%0b required all zero",
                     eng_start, busy, vga_plot);
        end
        rst = 1'b0;
        check_quiet(20, "post_reset");
        push_one(2);
        run_job(2);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_eng    = '0;
        eng_done   = '0;
        eng_x      = '0;
        eng_y      = '0;
        eng_colour = '0;
        eng_plot   = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_random_queue();
        test_isolation();
        test_full();
        test_watchdog();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule : tb_draw_sequencer

`default_nettype wire
